// File: rtl/ad9866_cfg_pkg.sv
// Shared types, register addresses and the power-up register table for the
// AD9866 serial-port sequencer.
package ad9866_cfg_pkg;

    // One register write: 6-bit register address plus 8-bit payload.
    typedef struct packed {
        logic [5:0] addr;
        logic [7:0] data;
    } frame_t;

    localparam logic [5:0] RX_GAIN_ADDR = 6'h09;
    localparam logic [5:0] TX_GAIN_ADDR = 6'h0A;

    localparam int unsigned INIT_LEN_MAX = 32;

    // Sequencer states.
    typedef enum logic [2:0] {
        RST_HOLD,
        RST_WAIT,
        INIT,
        IDLE,
        LOAD,
        SHIFT,
        GAP
    } seq_state_t;

    // Serializer phases.
    typedef enum logic [1:0] {
        SH_IDLE,
        SH_LOAD,
        SH_LOW,
        SH_HIGH
    } shift_phase_t;

    // Owner of the frame currently on the wire; NONE for table writes.
    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_CFG,
        REQ_RX,
        REQ_TX
    } requester_t;

    // Power-up register table. Entry 0 is the soft reset; the rest set up
    // clocking, the RX/TX filters and half-duplex operation. Entries beyond
    // the populated ones rewrite register 0 with its idle value.
    function automatic frame_t init_entry(input logic [4:0] idx);
        frame_t e;
        case (idx)
            5'd0:    e = '{addr: 6'h00, data: 8'h80};  // soft reset
            5'd1:    e = '{addr: 6'h01, data: 8'h54};  // clock source / PLL
            5'd2:    e = '{addr: 6'h02, data: 8'h00};  // clock output setup
            5'd3:    e = '{addr: 6'h04, data: 8'h36};  // RX filter
            5'd4:    e = '{addr: 6'h05, data: 8'h01};  // TX filter
            5'd5:    e = '{addr: 6'h06, data: 8'h00};  // interface mode
            5'd6:    e = '{addr: 6'h07, data: 8'h21};  // half-duplex enable
            5'd7:    e = '{addr: 6'h08, data: 8'h00};  // half-duplex timing
            default: e = '{addr: 6'h00, data: 8'h00};
        endcase
        return e;
    endfunction

    // Wire format, MSB first: write flag (0), address, pad bit (0), data.
    function automatic logic [15:0] spi_word(input logic [5:0] addr,
                                             input logic [7:0] data);
        return {1'b0, addr, 1'b0, data};
    endfunction

endpackage

// File: rtl/ad9866_spi_shifter.sv
// 16-bit MSB-first serializer for the AD9866 3-wire port. A start strobe
// loads the word and drops SEN_N; each bit gets CLK_DIV cycles of SCLK low
// followed by CLK_DIV cycles high. done strobes in the cycle whose edge
// raises SEN_N again.
module ad9866_spi_shifter
    import ad9866_cfg_pkg::*;
#(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] word,
    output logic        done,
    output logic        sclk,
    output logic        sdio,
    output logic        sen_n
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    shift_phase_t phase;
    shift_phase_t phase_next;
    logic [14:0]  shreg;
    logic [3:0]   bit_cnt;
    logic [7:0]   div_cnt;
    logic         div_end;

    // Phase register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase <= SH_IDLE;
        end else begin
            phase <= phase_next;
        end
    end

    // Phase sequencing and the end-of-frame strobe.
    always_comb begin
        phase_next = phase;
        done       = 1'b0;
        div_end    = (div_cnt == DIV_LAST);
        case (phase)
            SH_IDLE: if (start) phase_next = SH_LOAD;
            SH_LOAD: phase_next = SH_LOW;
            SH_LOW:  if (div_end) phase_next = SH_HIGH;
            SH_HIGH: begin
                if (div_end) begin
                    if (bit_cnt == '0) begin
                        phase_next = SH_IDLE;
                        done       = 1'b1;
                    end else begin
                        phase_next = SH_LOW;
                    end
                end
            end
            default: phase_next = SH_IDLE;
        endcase
    end

    // Pin drivers, shift register and half-period / bit counters.
    // SDIO only moves on the edge that also drives SCLK low.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            sclk    <= 1'b0;
            sdio    <= 1'b0;
            sen_n   <= 1'b1;
        end else begin
            case (phase)
                SH_IDLE: begin
                    if (start) begin
                        shreg   <= word[14:0];
                        sdio    <= word[15];
                        sen_n   <= 1'b0;
                        sclk    <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= 4'd15;
                    end
                end
                SH_LOAD: begin
                    div_cnt <= '0;
                end
                SH_LOW: begin
                    if (div_end) begin
                        sclk    <= 1'b1;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                SH_HIGH: begin
                    if (div_end) begin
                        sclk    <= 1'b0;
                        div_cnt <= '0;
                        if (bit_cnt == '0) begin
                            sen_n <= 1'b1;
                            sdio  <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt - 4'd1;
                            sdio    <= shreg[14];
                            shreg   <= {shreg[13:0], 1'b0};
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ad9866_spi_sequencer.sv
// AD9866 configuration controller: drives the chip reset, plays the
// power-up register table, then arbitrates runtime writes from the generic
// config, RX gain and TX gain requesters (fixed priority in that order).
module ad9866_spi_sequencer
    import ad9866_cfg_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned RESET_HOLD = 1024,
    parameter int unsigned INIT_LEN   = 8
) (
    input  logic       AD9866clk,
    input  logic       extreset,
    input  logic       cfg_req,
    input  logic [5:0] cfg_addr,
    input  logic [7:0] cfg_data,
    output logic       cfg_ack,
    input  logic       rx_gain_req,
    input  logic [5:0] rx_gain,
    output logic       rx_gain_ack,
    input  logic       tx_gain_req,
    input  logic [5:0] tx_gain,
    output logic       tx_gain_ack,
    output logic       ad9866_sclk,
    output logic       ad9866_sdio,
    output logic       ad9866_sen_n,
    output logic       ad9866_rst_n,
    output logic       busy,
    output logic       init_done
);

    localparam int unsigned CNT_MAX  = (RESET_HOLD > 2 * CLK_DIV) ? RESET_HOLD : 2 * CLK_DIV;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [4:0]       IDX_LAST  = 5'(INIT_LEN - 1);

    seq_state_t       state;
    seq_state_t       state_next;
    requester_t       grant;
    requester_t       grant_next;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       idx;
    frame_t           init_frame;

    logic        cnt_clr;
    logic        cnt_inc;
    logic        idx_clr;
    logic        idx_inc;
    logic        set_init_done;
    logic        release_rst;
    logic        ack_pulse;
    logic        start;
    logic [15:0] word;
    logic        shift_done;

    ad9866_spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk     (AD9866clk),
        .reset_n (extreset),
        .start   (start),
        .word    (word),
        .done    (shift_done),
        .sclk    (ad9866_sclk),
        .sdio    (ad9866_sdio),
        .sen_n   (ad9866_sen_n)
    );

    // State register.
    always_ff @(posedge AD9866clk) begin
        if (!extreset) begin
            state <= RST_HOLD;
        end else begin
            state <= state_next;
        end
    end

    // Next state, arbitration and shifter launch; the granted frame is
    // handed to the shifter in the same cycle it is chosen.
    always_comb begin
        state_next    = state;
        grant_next    = grant;
        cnt_clr       = 1'b0;
        cnt_inc       = 1'b0;
        idx_clr       = 1'b0;
        idx_inc       = 1'b0;
        set_init_done = 1'b0;
        release_rst   = 1'b0;
        ack_pulse     = 1'b0;
        start         = 1'b0;
        word          = '0;
        init_frame    = init_entry(idx);
        case (state)
            RST_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_next  = RST_WAIT;
                    cnt_clr     = 1'b1;
                    release_rst = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RST_WAIT: begin
                if (cnt == HOLD_LAST) begin
                    state_next = INIT;
                    cnt_clr    = 1'b1;
                    idx_clr    = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            INIT: begin
                start      = 1'b1;
                word       = spi_word(init_frame.addr, init_frame.data);
                grant_next = REQ_NONE;
                state_next = LOAD;
            end
            IDLE: begin
                if (cfg_req) begin
                    start      = 1'b1;
                    word       = spi_word(cfg_addr, cfg_data);
                    grant_next = REQ_CFG;
                    state_next = LOAD;
                end else if (rx_gain_req) begin
                    start      = 1'b1;
                    word       = spi_word(RX_GAIN_ADDR, {2'b01, rx_gain});
                    grant_next = REQ_RX;
                    state_next = LOAD;
                end else if (tx_gain_req) begin
                    start      = 1'b1;
                    word       = spi_word(TX_GAIN_ADDR, {2'b01, tx_gain});
                    grant_next = REQ_TX;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = SHIFT;
            end
            SHIFT: begin
                if (shift_done) begin
                    state_next = GAP;
                    cnt_clr    = 1'b1;
                    ack_pulse  = 1'b1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_clr = 1'b1;
                    if (init_done) begin
                        state_next = IDLE;
                    end else if (idx == IDX_LAST) begin
                        set_init_done = 1'b1;
                        state_next    = IDLE;
                    end else begin
                        idx_inc    = 1'b1;
                        state_next = INIT;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_next = RST_HOLD;
        endcase
    end

    // Counters, grant owner and registered outputs.
    always_ff @(posedge AD9866clk) begin
        if (!extreset) begin
            cnt          <= '0;
            idx          <= '0;
            grant        <= REQ_NONE;
            cfg_ack      <= 1'b0;
            rx_gain_ack  <= 1'b0;
            tx_gain_ack  <= 1'b0;
            init_done    <= 1'b0;
            ad9866_rst_n <= 1'b0;
            busy         <= 1'b1;
        end else begin
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (idx_clr) begin
                idx <= '0;
            end else if (idx_inc) begin
                idx <= idx + 5'd1;
            end
            grant       <= grant_next;
            cfg_ack     <= ack_pulse && (grant == REQ_CFG);
            rx_gain_ack <= ack_pulse && (grant == REQ_RX);
            tx_gain_ack <= ack_pulse && (grant == REQ_TX);
            if (set_init_done) begin
                init_done <= 1'b1;
            end
            if (release_rst) begin
                ad9866_rst_n <= 1'b1;
            end
            busy <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_ad9866_spi_sequencer.sv
// Bench for ad9866_spi_sequencer: a timeline model predicts every pin each
// cycle from frame start times and wire words; an SPI monitor decodes frames
// for literal checks of table, cfg, gain and reset scenarios.
`timescale 1ns/1ps
module tb_ad9866_spi_sequencer;

    localparam int D         = 2;
    localparam int RH        = 8;
    localparam int L         = 2;
    localparam int FRAME_CYC = 2 + 34 * D;
    localparam int T_DONE    = 2 * RH + L * FRAME_CYC;
    localparam logic [15:0] INIT_WORDS [2] = '{16'h0080, 16'h0254};

    logic       clk = 1'b0;
    logic       extreset;
    logic       cfg_req, rx_gain_req, tx_gain_req;
    logic [5:0] cfg_addr, rx_gain, tx_gain;
    logic [7:0] cfg_data;
    logic       cfg_ack, rx_gain_ack, tx_gain_ack;
    logic       ad9866_sclk, ad9866_sdio, ad9866_sen_n, ad9866_rst_n;
    logic       busy, init_done;

    ad9866_spi_sequencer #(
        .CLK_DIV    (D),
        .RESET_HOLD (RH),
        .INIT_LEN   (L)
    ) dut (
        .AD9866clk    (clk),
        .extreset     (extreset),
        .cfg_req      (cfg_req),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .cfg_ack      (cfg_ack),
        .rx_gain_req  (rx_gain_req),
        .rx_gain      (rx_gain),
        .rx_gain_ack  (rx_gain_ack),
        .tx_gain_req  (tx_gain_req),
        .tx_gain      (tx_gain),
        .tx_gain_ack  (tx_gain_ack),
        .ad9866_sclk  (ad9866_sclk),
        .ad9866_sdio  (ad9866_sdio),
        .ad9866_sen_n (ad9866_sen_n),
        .ad9866_rst_n (ad9866_rst_n),
        .busy         (busy),
        .init_done    (init_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit armed  = 1'b0;

    // Runtime frames expected on the wire: LOAD cycle, word, owner (1..3).
    int          sched_start[$];
    logic [15:0] sched_word[$];
    int          sched_who[$];

    logic [15:0] decoded[$];
    logic [15:0] mon_shift  = '0;
    int          mon_bits   = 0;
    logic        prev_sclk  = 1'b0;
    logic        prev_sdio  = 1'b0;
    logic        prev_sen   = 1'b1;
    logic        prev_rst   = 1'b0;
    int          rst_rise_cyc = -1;
    int          n_ack[3];

    logic       e_sen, e_sclk, e_sdio, e_busy;
    logic [2:0] e_ack;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    task automatic schedule(input int c, input bit w_cfg, input bit w_rx, input bit w_tx);
        int k = 0;
        if (w_cfg) begin
            sched_start.push_back(c + 1 + k * FRAME_CYC);
            sched_word.push_back({1'b0, cfg_addr, 1'b0, cfg_data});
            sched_who.push_back(1);
            k++;
        end
        if (w_rx) begin
            sched_start.push_back(c + 1 + k * FRAME_CYC);
            sched_word.push_back({1'b0, 6'h09, 1'b0, 2'b01, rx_gain});
            sched_who.push_back(2);
            k++;
        end
        if (w_tx) begin
            sched_start.push_back(c + 1 + k * FRAME_CYC);
            sched_word.push_back({1'b0, 6'h0A, 1'b0, 2'b01, tx_gain});
            sched_who.push_back(3);
        end
    endtask

    task automatic eval_frame(input int s, input logic [15:0] w, input int who, input bit runtime);
        int j;
        j = cyc - s;
        if (j >= 0 && j <= 32 * D) begin
            e_sen  = 1'b0;
            e_sclk = (j >= 1) && ((((j - 1) / D) % 2) == 1);
            e_sdio = (j == 0) ? w[15] : w[15 - (j - 1) / (2 * D)];
        end
        if (j == 32 * D + 1 && who != 0) e_ack[who - 1] = 1'b1;
        if (runtime && j >= 0 && j <= 34 * D) e_busy = 1'b1;
    endtask

    // Cycle index since the last reset edge; reset discards pending frames.
    always @(posedge clk) begin
        if (!extreset) begin
            cyc   <= 0;
            armed <= 1'b1;
            sched_start.delete();
            sched_word.delete();
            sched_who.delete();
        end else begin
            cyc <= cyc + 1;
        end
    end

    // Per-cycle comparison against the timeline model, plus the SPI monitor.
    always @(negedge clk) begin
        if (armed) begin
            e_sen  = 1'b1;
            e_sclk = 1'b0;
            e_sdio = 1'b0;
            e_ack  = 3'b000;
            e_busy = (cyc < T_DONE);
            for (int i = 0; i < L; i++) eval_frame(2 * RH + i * FRAME_CYC + 1, INIT_WORDS[i], 0, 1'b0);
            for (int q = 0; q < sched_start.size(); q++) eval_frame(sched_start[q], sched_word[q], sched_who[q], 1'b1);

            check("rst_n", ad9866_rst_n, cyc >= RH);
            check("init_done", init_done, cyc >= T_DONE);
            check("sen_n", ad9866_sen_n, e_sen);
            check("sclk", ad9866_sclk, e_sclk);
            if (!e_sen) check("sdio", ad9866_sdio, e_sdio);
            check("cfg_ack", cfg_ack, e_ack[0]);
            check("rx_gain_ack", rx_gain_ack, e_ack[1]);
            check("tx_gain_ack", tx_gain_ack, e_ack[2]);
            check("busy", busy, e_busy);
            if (prev_sclk && ad9866_sclk) check("sdio_stable", ad9866_sdio, prev_sdio);

            if (prev_sen && !ad9866_sen_n) mon_bits = 0;
            if (!ad9866_sen_n && !prev_sclk && ad9866_sclk) begin
                mon_shift = {mon_shift[14:0], ad9866_sdio};
                mon_bits++;
            end
            if (!prev_sen && ad9866_sen_n && mon_bits == 16) decoded.push_back(mon_shift);
            if (ad9866_rst_n && !prev_rst) rst_rise_cyc = cyc;
            if (cfg_ack) n_ack[0]++;
            if (rx_gain_ack) n_ack[1]++;
            if (tx_gain_ack) n_ack[2]++;

            prev_sclk = ad9866_sclk;
            prev_sdio = ad9866_sdio;
            prev_sen  = ad9866_sen_n;
            prev_rst  = ad9866_rst_n;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // what: 0 init_done high, 1 busy low, 2 cyc reaches target
    task automatic wait_for(input int what, input int target, input int limit, input string name);
        int n = 0;
        while (n < limit && !((what == 0 && init_done === 1'b1) ||
                              (what == 1 && busy === 1'b0) ||
                              (what == 2 && cyc >= target))) begin
            step();
            n++;
        end
        if (n >= limit) check({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic do_reset(input int hold);
        extreset    = 1'b0;
        cfg_req     = 1'b0;
        rx_gain_req = 1'b0;
        tx_gain_req = 1'b0;
        repeat (hold) step();
        extreset = 1'b1;
    endtask

    initial begin
        int c;
        int base;
        int n;
        cfg_addr = '0; cfg_data = '0; rx_gain = '0; tx_gain = '0;
        n_ack = '{0, 0, 0};

        // Power-up sequence
        do_reset(3);
        base = decoded.size();
        wait_for(0, 0, 400, "init1");
        check("init_done_cycle", cyc, 156);
        check("rst_low_cycles", rst_rise_cyc, 8);
        check("init_frames", decoded.size() - base, 2);
        if (decoded.size() >= base + 2) begin
            check("init_word0", decoded[base], 16'h0080);
            check("init_word1", decoded[base + 1], 16'h0254);
        end

        // Single cfg write
        c = cyc;
        base = decoded.size();
        n_ack = '{0, 0, 0};
        cfg_addr = 6'h12; cfg_data = 8'hA5; cfg_req = 1'b1;
        schedule(c, 1'b1, 1'b0, 1'b0);
        n = 0;
        while (cfg_ack !== 1'b1 && n < 200) begin step(); n++; end
        check("cfg_ack_latency", cyc - (c + 1), 65);
        cfg_req = 1'b0;
        wait_for(1, 0, 200, "cfg_idle");
        check("busy_drop_cycle", cyc - c, 70);
        check("cfg_frames", decoded.size() - base, 1);
        if (decoded.size() > base) check("cfg_word", decoded[base], 16'h24A5);
        check("cfg_ack_count", n_ack[0], 1);

        // Three simultaneous requests
        c = cyc;
        base = decoded.size();
        n_ack = '{0, 0, 0};
        cfg_addr = 6'h12; cfg_data = 8'h3C; rx_gain = 6'h2A; tx_gain = 6'h15;
        cfg_req = 1'b1; rx_gain_req = 1'b1; tx_gain_req = 1'b1;
        schedule(c, 1'b1, 1'b1, 1'b1);
        n = 0;
        while ((cfg_req || rx_gain_req || tx_gain_req) && n < 400) begin
            step();
            n++;
            if (cfg_ack === 1'b1) cfg_req = 1'b0;
            if (rx_gain_ack === 1'b1) rx_gain_req = 1'b0;
            if (tx_gain_ack === 1'b1) tx_gain_req = 1'b0;
        end
        wait_for(1, 0, 200, "prio_idle");
        check("prio_frames", decoded.size() - base, 3);
        if (decoded.size() >= base + 3) begin
            check("prio_word0", decoded[base], 16'h243C);
            check("prio_word1", decoded[base + 1], 16'h126A);
            check("prio_word2", decoded[base + 2], 16'h1455);
        end
        check("prio_cfg_acks", n_ack[0], 1);
        check("prio_rx_acks", n_ack[1], 1);
        check("prio_tx_acks", n_ack[2], 1);

        // RX gain request raised during init
        do_reset(2);
        base = decoded.size();
        n_ack = '{0, 0, 0};
        wait_for(2, 50, 200, "reach_init");
        rx_gain = 6'h2A; rx_gain_req = 1'b1;
        schedule(T_DONE, 1'b0, 1'b1, 1'b0);
        wait_for(0, 0, 400, "init2");
        check("init2_done_cycle", cyc, 156);
        n = 0;
        while (rx_gain_ack !== 1'b1 && n < 200) begin step(); n++; end
        check("held_rx_ack_cycle", cyc, 222);
        rx_gain_req = 1'b0;
        wait_for(1, 0, 200, "held_idle");
        check("held_frames", decoded.size() - base, 3);
        if (decoded.size() >= base + 3) begin
            check("held_word0", decoded[base], 16'h0080);
            check("held_word1", decoded[base + 1], 16'h0254);
            check("held_word2", decoded[base + 2], 16'h126A);
        end
        check("held_rx_acks", n_ack[1], 1);

        // Reset in the middle of bit 7 of a cfg frame
        c = cyc;
        n_ack = '{0, 0, 0};
        cfg_addr = 6'h3F; cfg_data = 8'h81; cfg_req = 1'b1;
        schedule(c, 1'b1, 1'b0, 1'b0);
        repeat (34) step();
        check("mid_sen_low", ad9866_sen_n, 1'b0);
        extreset = 1'b0;
        cfg_req  = 1'b0;
        step();
        check("mid_rst_sen_n", ad9866_sen_n, 1'b1);
        check("mid_rst_rst_n", ad9866_rst_n, 1'b0);
        check("mid_rst_no_ack", cfg_ack, 1'b0);
        check("mid_rst_init_done", init_done, 1'b0);
        base = decoded.size();
        step();
        extreset = 1'b1;
        wait_for(0, 0, 400, "init3");
        check("init3_done_cycle", cyc, 156);
        check("reinit_frames", decoded.size() - base, 2);
        if (decoded.size() >= base + 2) begin
            check("reinit_word0", decoded[base], 16'h0080);
            check("reinit_word1", decoded[base + 1], 16'h0254);
        end
        check("mid_rst_ack_count", n_ack[0], 0);

        repeat (4) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
